cp0: RTL and testbench

Coprocessor-0 for the five-stage MIPS pipeline: the consumer of the fetch stage's exception reporting and the producer of its redirect controls. It collects the exception code and branch-delay flag travelling down the pipeline plus the six hardware interrupt lines. It decides whether to take an interrupt or exception, latches the victim PC into EPC, and drives `interrupt`, `exception` and `EPC` back to fetch. It also services `mfc0`/`mtc0` for SR(12), Cause(13), EPC(14) and PrID(15).

---
 rtl/cp0_pkg.sv | 58 +++++
 rtl/cp0_int_arbiter.sv | 18 +
 rtl/cp0.sv | 135 +++++++++++++
 tb/tb_cp0.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared definitions for coprocessor 0: register indices, exception codes,
// SR/Cause field positions, handler-mode encoding and register packing helpers.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int SR_IE_BIT     = 0;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IM_LSB     = 10;
    localparam int SR_IM_MSB     = 15;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_EXC_MSB = 6;
    localparam int CAUSE_IP_LSB  = 10;
    localparam int CAUSE_IP_MSB  = 15;
    localparam int CAUSE_BD_BIT  = 31;

    // The handler mode is the SR.EXL bit itself.
    typedef enum logic {
        MODE_NORMAL     = 1'b0,
        MODE_IN_HANDLER = 1'b1
    } mode_e;

    function automatic logic [31:0] victim_epc(input logic [31:0] pc, input logic bd);
        logic [31:0] target;
        target = bd ? (pc - 32'd4) : pc;
        return {target[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl,
                                            input logic ie);
        logic [31:0] sr;
        sr = 32'd0;
        sr[SR_IM_MSB:SR_IM_LSB] = im;
        sr[SR_EXL_BIT]          = exl;
        sr[SR_IE_BIT]           = ie;
        return sr;
    endfunction

    function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip,
                                               input logic [4:0] exc_code);
        logic [31:0] cause;
        cause = 32'd0;
        cause[CAUSE_BD_BIT]                 = bd;
        cause[CAUSE_IP_MSB:CAUSE_IP_LSB]    = ip;
        cause[CAUSE_EXC_MSB:CAUSE_EXC_LSB]  = exc_code;
        return cause;
    endfunction

endpackage

// File: rtl/cp0_int_arbiter.sv
// Combinational interrupt/exception decision. Interrupts beat exceptions and
// nothing is taken while the handler is already running (EXL set).
import cp0_pkg::*;

module cp0_int_arbiter (
    input  logic [5:0] hw_int,
    input  logic [5:0] im,
    input  logic       ie,
    input  logic       exl,
    input  logic [4:0] exc_code,
    output logic       interrupt,
    output logic       exception
);

    assign interrupt = (|(hw_int & im)) & ie & ~exl;
    assign exception = (exc_code != EXC_INT) & ~exl & ~interrupt;

endmodule

// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC/PrID registers, exception entry and eret exit,
// and the zero-cycle interrupt/exception redirect requests sent to fetch.
import cp0_pkg::*;

module cp0 #(
    parameter logic [31:0] PRID_VALUE   = 32'h0000_2019,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        We,
    input  logic [31:0] PC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        interrupt,
    output logic        exception,
    output logic [31:0] EPC,
    output logic [31:0] DOut
);

    // Fetch owns the vector; the value is carried here so both sides share one definition.
    logic unused_handler_addr;
    assign unused_handler_addr = ^HANDLER_ADDR;

    mode_e       mode_q, mode_d;
    logic [5:0]  im_q, im_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;

    logic        exl;
    logic        request;
    logic        sr_wr;
    logic        epc_wr;

    assign exl    = (mode_q == MODE_IN_HANDLER);
    assign sr_wr  = We && (A2 == REG_SR);
    assign epc_wr = We && (A2 == REG_EPC);

    cp0_int_arbiter u_arbiter (
        .hw_int    (HWInt),
        .im        (im_q),
        .ie        (ie_q),
        .exl       (exl),
        .exc_code  (ExcCodeIn),
        .interrupt (interrupt),
        .exception (exception)
    );

    assign request = interrupt | exception;

    // Handler-mode FSM; eret wins over a simultaneous software write of EXL.
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            MODE_NORMAL: begin
                if (request) begin
                    mode_d = MODE_IN_HANDLER;
                end else if (sr_wr && DIn[SR_EXL_BIT] && !EXLClr) begin
                    mode_d = MODE_IN_HANDLER;
                end
            end
            MODE_IN_HANDLER: begin
                if (EXLClr || (sr_wr && !DIn[SR_EXL_BIT])) begin
                    mode_d = MODE_NORMAL;
                end
            end
            default: mode_d = MODE_NORMAL;
        endcase
    end

    // A taken request owns the register file for that edge; mtc0 is dropped.
    always_comb begin
        im_d  = im_q;
        ie_d  = ie_q;
        bd_d  = bd_q;
        ip_d  = HWInt;
        exc_d = exc_q;
        epc_d = epc_q;
        if (request) begin
            bd_d  = BDIn;
            exc_d = interrupt ? EXC_INT : ExcCodeIn;
            epc_d = victim_epc(PC, BDIn);
        end else begin
            if (sr_wr) begin
                im_d = DIn[SR_IM_MSB:SR_IM_LSB];
                ie_d = DIn[SR_IE_BIT];
            end
            if (epc_wr) begin
                epc_d = {DIn[31:2], 2'b00};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q <= MODE_NORMAL;
            im_q   <= 6'd0;
            ie_q   <= 1'b0;
            bd_q   <= 1'b0;
            ip_q   <= 6'd0;
            exc_q  <= 5'd0;
            epc_q  <= 32'd0;
        end else begin
            mode_q <= mode_d;
            im_q   <= im_d;
            ie_q   <= ie_d;
            bd_q   <= bd_d;
            ip_q   <= ip_d;
            exc_q  <= exc_d;
            epc_q  <= epc_d;
        end
    end

    assign EPC = epc_q;

    always_comb begin
        DOut = 32'd0;
        case (A1)
            REG_SR:    DOut = pack_sr(im_q, exl, ie_q);
            REG_CAUSE: DOut = pack_cause(bd_q, ip_q, exc_q);
            REG_EPC:   DOut = epc_q;
            REG_PRID:  DOut = PRID_VALUE;
            default:   DOut = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0.sv
// Directed bench for cp0: a word-level model of SR/Cause/EPC checked every
// cycle, plus hand-computed expectations along the directed sequence.
module tb_cp0;

    logic        clk;
    logic        reset;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        We;
    logic [31:0] PC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        interrupt;
    logic        exception;
    logic [31:0] EPC;
    logic [31:0] DOut;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    localparam logic [31:0] PRID = 32'h0000_2019;

    cp0 dut (
        .clk       (clk),
        .reset     (reset),
        .A1        (A1),
        .A2        (A2),
        .DIn       (DIn),
        .We        (We),
        .PC        (PC),
        .BDIn      (BDIn),
        .ExcCodeIn (ExcCodeIn),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .interrupt (interrupt),
        .exception (exception),
        .EPC       (EPC),
        .DOut      (DOut)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-level model: registers held as whole 32-bit words with masks
    logic [31:0] m_sr, m_cause, m_epc;

    function automatic logic m_int();
        return (|(HWInt & m_sr[15:10])) & m_sr[0] & ~m_sr[1];
    endfunction

    function automatic logic m_exc();
        return (ExcCodeIn != 5'd0) & ~m_sr[1] & ~m_int();
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        case (idx)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_sr    <= 32'd0;
            m_cause <= 32'd0;
            m_epc   <= 32'd0;
        end else if (m_int() || m_exc()) begin
            m_sr    <= m_sr | 32'h0000_0002;
            m_cause <= ({31'd0, BDIn} << 31) | ({26'd0, HWInt} << 10)
                       | ({27'd0, (m_int() ? 5'd0 : ExcCodeIn)} << 2);
            m_epc   <= (BDIn ? PC - 32'd4 : PC) & 32'hFFFF_FFFC;
        end else begin
            m_cause <= (m_cause & 32'hFFFF_03FF) | ({26'd0, HWInt} << 10);
            m_sr    <= ((We && A2 == 5'd12) ? (DIn & 32'h0000_FC03) : m_sr)
                       & (EXLClr ? 32'hFFFF_FFFD : 32'hFFFF_FFFF);
            if (We && A2 == 5'd14) m_epc <= DIn & 32'hFFFF_FFFC;
        end
    end

    // Scoreboard
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_interrupt", {31'd0, interrupt}, {31'd0, m_int()});
            check("cmp_exception", {31'd0, exception}, {31'd0, m_exc()});
            check("cmp_epc", EPC, m_epc);
            check("cmp_dout", DOut, m_read(A1));
        end
    end

    // Driver tasks
    task automatic cyc_start();
        @(posedge clk);
        #1;
        We = 1'b0; EXLClr = 1'b0; ExcCodeIn = 5'd0; BDIn = 1'b0;
    endtask

    task automatic cyc_check();
        @(negedge clk);
        #1;
    endtask

    task automatic read_chk(input logic [4:0] idx, input logic [31:0] exp, input string name);
        A1 = idx;
        #1;
        check(name, DOut, exp);
    endtask

    task automatic mtc0(input logic [4:0] idx, input logic [31:0] data);
        We = 1'b1; A2 = idx; DIn = data;
    endtask

    initial begin
        reset = 1'b0; A1 = 5'd12; A2 = 5'd0; DIn = 32'd0; We = 1'b0;
        PC = 32'd0; BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset  = 1'b1;
        cmp_en = 1'b1;

        // Reset state, with all interrupt lines raised but IE clear
        cyc_start(); HWInt = 6'h3F;
        cyc_check();
        check("rst_interrupt", {31'd0, interrupt}, 32'd0);
        check("rst_exception", {31'd0, exception}, 32'd0);
        read_chk(5'd12, 32'd0, "rst_sr");
        read_chk(5'd13, 32'd0, "rst_cause");
        read_chk(5'd14, 32'd0, "rst_epc");
        read_chk(5'd15, 32'h0000_2019, "rst_prid");

        // Enable IM0 + IE, then take an interrupt
        cyc_start(); HWInt = 6'd0; mtc0(5'd12, 32'h0000_0401);
        cyc_check();
        cyc_start(); HWInt = 6'd1; PC = 32'h0000_3010;
        cyc_check();
        check("int_take", {31'd0, interrupt}, 32'd1);
        check("int_no_exc", {31'd0, exception}, 32'd0);
        cyc_start(); HWInt = 6'd0; PC = 32'h0000_3200;
        cyc_check();
        check("int_epc", EPC, 32'h0000_3010);
        read_chk(5'd13, 32'h0000_0400, "int_cause");
        read_chk(5'd12, 32'h0000_0403, "int_sr_exl");

        // eret with a pending enabled interrupt
        cyc_start(); EXLClr = 1'b1; HWInt = 6'd1;
        cyc_check();
        check("eret_masked", {31'd0, interrupt}, 32'd0);

        // Interrupt colliding with an mtc0 to EPC
        cyc_start(); HWInt = 6'd1; PC = 32'h0000_3000; mtc0(5'd14, 32'h0000_5000);
        cyc_check();
        check("eret_pending_int", {31'd0, interrupt}, 32'd1);
        read_chk(5'd12, 32'h0000_0401, "eret_sr");
        cyc_start(); HWInt = 6'd0; EXLClr = 1'b1;
        cyc_check();
        check("collide_epc", EPC, 32'h0000_3000);

        // Overflow in a delay slot
        cyc_start(); ExcCodeIn = 5'd12; BDIn = 1'b1; PC = 32'h0000_3024;
        cyc_check();
        check("bd_exc", {31'd0, exception}, 32'd1);
        check("bd_no_int", {31'd0, interrupt}, 32'd0);

        // Masked AdEL while in the handler
        cyc_start(); ExcCodeIn = 5'd4; PC = 32'h0000_4444;
        cyc_check();
        check("bd_epc", EPC, 32'h0000_3020);
        read_chk(5'd13, 32'h8000_0030, "bd_cause");
        read_chk(5'd12, 32'h0000_0403, "bd_sr");
        check("mask_exc", {31'd0, exception}, 32'd0);
        cyc_start(); EXLClr = 1'b1;
        cyc_check();
        check("mask_epc_kept", EPC, 32'h0000_3020);

        // RI together with an enabled interrupt: interrupt wins
        cyc_start(); ExcCodeIn = 5'd10; HWInt = 6'd1; PC = 32'h0000_3100;
        cyc_check();
        check("prio_int", {31'd0, interrupt}, 32'd1);
        check("prio_no_exc", {31'd0, exception}, 32'd0);

        // Cause is read-only; SR keeps only its defined fields
        cyc_start(); HWInt = 6'd0; mtc0(5'd13, 32'hFFFF_FFFF);
        cyc_check();
        check("prio_epc", EPC, 32'h0000_3100);
        read_chk(5'd13, 32'h0000_0400, "prio_cause");
        cyc_start(); mtc0(5'd12, 32'hFFFF_FFFF);
        cyc_check();
        read_chk(5'd13, 32'd0, "cause_ro");
        cyc_start(); mtc0(5'd14, 32'h0000_1237);
        cyc_check();
        read_chk(5'd12, 32'h0000_FC03, "sr_mask");
        cyc_start(); mtc0(5'd12, 32'd0);
        cyc_check();
        check("epc_write_align", EPC, 32'h0000_1234);
        read_chk(5'd0, 32'd0, "read_idx0");
        read_chk(5'd31, 32'd0, "read_idx31");

        // AdES in a delay slot at PC=2: EPC wraps
        cyc_start(); ExcCodeIn = 5'd5; BDIn = 1'b1; PC = 32'h0000_0002;
        cyc_check();
        check("wrap_exc", {31'd0, exception}, 32'd1);
        cyc_start(); mtc0(5'd12, 32'h0000_0401);
        cyc_check();
        check("wrap_epc", EPC, 32'hFFFF_FFFC);
        read_chk(5'd13, 32'h8000_0014, "wrap_cause");

        // Asynchronous reset in the middle of an interrupt request
        cyc_start(); HWInt = 6'd1; PC = 32'h0000_3300; A1 = 5'd14;
        cyc_check();
        check("pre_rst_int", {31'd0, interrupt}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check("async_int", {31'd0, interrupt}, 32'd0);
        check("async_exc", {31'd0, exception}, 32'd0);
        check("async_epc", EPC, 32'd0);
        check("async_dout", DOut, 32'd0);
        @(posedge clk);
        @(negedge clk);
        HWInt = 6'd0;
        reset = 1'b1;
        cyc_start();
        cyc_check();
        check("post_rst_epc", EPC, 32'd0);
        read_chk(5'd12, 32'd0, "post_rst_sr");
        read_chk(5'd13, 32'd0, "post_rst_cause");

        cmp_en = 1'b0;
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
